// File: rtl/calc_operand_sequencer.sv
// -----------------------------------------------------------------------------
// calc_operand_sequencer
//
// Front-end input stage of the calculator. Synchronises and debounces the raw
// ENTER and CLEAR buttons, then steps a four-state entry FSM
// (operand A -> operand B -> operator -> done). Each stage presents a
// registered value together with a one-cycle load strobe that drives the
// enable of the downstream operand/operator register.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   sw         in   WIDTH  operand switches (quasi-static, not synchronised)
//   op_sw      in   2      operator select switches
//   btn_enter  in   1      raw ENTER button, asynchronous to clk
//   btn_clear  in   1      raw CLEAR button, asynchronous to clk
//   data_out   out  WIDTH  registered operand value for downstream Data
//   load_a     out  1      one-cycle enable for the operand-A register
//   load_b     out  1      one-cycle enable for the operand-B register
//   op_out     out  2      registered operator code
//   exec       out  1      one-cycle pulse: operator captured
//   stage      out  2      FSM state: 0 S_A, 1 S_B, 2 S_OP, 3 S_DONE
// -----------------------------------------------------------------------------
module calc_operand_sequencer #(
    parameter int WIDTH     = 5,
    parameter int DB_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       op_sw,
    input  logic             btn_enter,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] data_out,
    output logic             load_a,
    output logic             load_b,
    output logic [1:0]       op_out,
    output logic             exec,
    output logic [1:0]       stage
);

    localparam logic [1:0] S_A    = 2'd0;
    localparam logic [1:0] S_B    = 2'd1;
    localparam logic [1:0] S_OP   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int              CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // Bit 0 carries ENTER, bit 1 carries CLEAR through the whole front end.
    localparam int BTN_ENTER = 0;
    localparam int BTN_CLEAR = 1;

    logic [1:0]       btn_s;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       stable_q;
    logic [1:0]       stable_d;
    logic [1:0]       stable_dly_q;
    logic [1:0]       evt_s;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    logic [1:0]       stage_q,  stage_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic [1:0]       op_q,     op_d;
    logic             load_a_q, load_a_d;
    logic             load_b_q, load_b_d;
    logic             exec_q,   exec_d;

    assign btn_s = {btn_clear, btn_enter};

    // Two-flop synchroniser for both raw buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= btn_s;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next state: count consecutive edges on which the synchronised
    // level disagrees with the accepted level; accept on the DB_CYCLES-th.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != stable_q[b]) begin
                if (cnt_q[b] == CNT_MAX) begin
                    stable_d[b] = sync2_q[b];
                    cnt_d[b]    = {CNT_W{1'b0}};
                end else begin
                    cnt_d[b] = cnt_q[b] + CNT_W'(1);
                end
            end else begin
                cnt_d[b] = {CNT_W{1'b0}};
            end
        end
    end

    // Debounce state registers and the one-cycle-delayed stable level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q     <= 2'b00;
            stable_dly_q <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                cnt_q[b] <= {CNT_W{1'b0}};
            end
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int b = 0; b < 2; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    // Rising edge of the debounced level only: releases make no event.
    assign evt_s = stable_q & ~stable_dly_q;

    // Entry FSM next state. CLEAR has priority, so a same-cycle ENTER is lost.
    always_comb begin
        stage_d  = stage_q;
        data_d   = data_q;
        op_d     = op_q;
        load_a_d = 1'b0;
        load_b_d = 1'b0;
        exec_d   = 1'b0;
        if (evt_s[BTN_CLEAR]) begin
            stage_d = S_A;
            data_d  = {WIDTH{1'b0}};
            op_d    = 2'b00;
        end else if (evt_s[BTN_ENTER]) begin
            case (stage_q)
                S_A, S_DONE: begin
                    data_d   = sw;
                    load_a_d = 1'b1;
                    stage_d  = S_B;
                end
                S_B: begin
                    data_d   = sw;
                    load_b_d = 1'b1;
                    stage_d  = S_OP;
                end
                S_OP: begin
                    op_d    = op_sw;
                    exec_d  = 1'b1;
                    stage_d = S_DONE;
                end
                default: begin
                    stage_d = S_A;
                end
            endcase
        end else begin
            stage_d = stage_q;
        end
    end

    // FSM and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q  <= S_A;
            data_q   <= {WIDTH{1'b0}};
            op_q     <= 2'b00;
            load_a_q <= 1'b0;
            load_b_q <= 1'b0;
            exec_q   <= 1'b0;
        end else begin
            stage_q  <= stage_d;
            data_q   <= data_d;
            op_q     <= op_d;
            load_a_q <= load_a_d;
            load_b_q <= load_b_d;
            exec_q   <= exec_d;
        end
    end

    assign data_out = data_q;
    assign load_a   = load_a_q;
    assign load_b   = load_b_q;
    assign op_out   = op_q;
    assign exec     = exec_q;
    assign stage    = stage_q;

endmodule
